decoder_3x8_stream: RTL and testbench
=====================================

Name: decoder_3x8_stream

Overview:
- Streaming 3-to-8 one-hot decoder. It is the inverse of the team's 8x3 non-priority encoder and restores one-hot lines from 3-bit codes.
- Codes arrive over a valid/ready handshake and are buffered in a small FIFO. Each buffered code is presented as an 8-bit one-hot word on a second valid/ready handshake.
- En gates delivery in the same way En gates the encoder: when low, the output is zero and nothing is consumed.
- Sits between a code producer (encoder, serial link) and one-hot consumers (select lines, LED/row drivers).

Parameters:
- IW, 3, code width. Output width is OW = 2**IW, so 8 by default.
- DEPTH, 4, FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- En  in  1  output enable; high = deliver.
- clear  in  1  synchronous flush of the FIFO.
- in_code  in  IW  code to decode.
- in_valid  in  1  in_code is valid.
- in_ready  out  1  FIFO can accept a code.
- out_onehot  out  OW  decoded word, bit [in_code] set.
- out_valid  out  1  out_onehot is valid.
- out_ready  in  1  consumer accepts out_onehot.
- level  out  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (async assert, released synchronously by the clock domain):
  - wr_ptr = rd_ptr = 0, level = 0, memory contents don't-care.
  - out_valid = 0, out_onehot = 0, in_ready = 1.
- Push: in_valid && in_ready at a rising edge writes in_code to mem[wr_ptr], increments wr_ptr modulo DEPTH and increments level.
- Pop: out_valid && out_ready at a rising edge increments rd_ptr modulo DEPTH and decrements level.
- Combinational outputs from registered state:
  - in_ready = (level != DEPTH).
  - out_valid = En && (level != 0).
  - out_onehot = out_valid ? (1 << mem[rd_ptr]) : 0. Exactly one bit is set whenever out_valid is 1.
- Latency: a code pushed at edge t is visible on out_onehot after edge t, i.e. 1 cycle, provided the FIFO was empty and En = 1. There is no combinational pass-through from in to out.
- Derived occupancy states, for documentation and coverage only:
  - EMPTY (level = 0): out_valid = 0.
  - PARTIAL: both handshakes may fire.
  - FULL (level = DEPTH): in_ready = 0.
  - Transitions: EMPTY→PARTIAL on push-only; PARTIAL→FULL on push-only reaching DEPTH; FULL→PARTIAL on pop; PARTIAL→EMPTY on pop-only reaching 0; push+pop together leaves level unchanged.
- Boundary conditions:
  - Full: in_valid is ignored and nothing is written. A same-cycle pop does not allow a push in that cycle.
  - Empty: out_ready is ignored.
  - Pointer wrap: from DEPTH-1 the pointer goes to 0. Data order is preserved (FIFO).
  - En = 0: out_valid = 0 and out_onehot = 0, so no pop occurs. Pushes continue until FULL. When En rises, the head entry appears in the same cycle.
  - En toggling while out_ready = 1: only cycles with En = 1 pop.
  - clear = 1 at an edge sets pointers and level to 0 and discards any same-cycle push or pop. in_ready returns to 1 on the next cycle.
  - rst mid-stream: all entries are lost immediately, and outputs drop to their reset values without waiting for a clock.
  - Illegal in_code values cannot occur, because every IW-bit code maps to a valid one-hot word.

Decomposition:
- Shared package holds:
  - function onehot_decode(code) returning 1 << code, sized OW.
  - localparam-style constants OW = 2**IW and LW = clog2(DEPTH)+1.
- One natural sub-module, code_fifo. It is a generic IW-wide, DEPTH-deep synchronous FIFO with push/pop/clear, level, full and empty.
- The top level instantiates code_fifo and applies onehot_decode plus En gating.

Test Plan:
- Reset, En = 1, push codes 0..7 one per cycle, out_ready = 1 → out_onehot sequence 00000001, 00000010, …, 10000000, each 1 cycle after its push; level never exceeds 1.
- out_ready = 0, push 5 codes (3, 6, 1, 7, 0) → after 4 accepted, in_ready = 0, level = 4, code 0 not accepted. Then out_ready = 1 → 00001000, 01000000, 00000010, 10000000 in order.
- En = 0, push 2 then 4 → out_valid = 0 and out_onehot = 00000000 with level = 2. Raise En → 00000100 in the same cycle, then 00010000.
- Simultaneous push and pop at level = 2 for 6 cycles → level stays 2; pointers wrap past 3 → 0 with order preserved.
- level = 3, assert clear with in_valid = 1 and code 5 → next cycle level = 0, out_valid = 0, code 5 discarded.
- Assert rst asynchronously between edges with level = 3 → out_valid, out_onehot and level go to 0 immediately, and in_ready = 1.

Source files
------------

// File: rtl/decoder_3x8_stream_pkg.sv
// Shared constants and the code-to-one-hot helper for the streaming 3-to-8 decoder.
package decoder_3x8_stream_pkg;

   localparam int IW_DEF    = 3;
   localparam int DEPTH_DEF = 4;
   localparam int OW        = 2 ** IW_DEF;
   localparam int LW        = $clog2(DEPTH_DEF) + 1;

   function automatic logic [OW-1:0] onehot_decode(input logic [IW_DEF-1:0] code);
      return OW'(1) << code;
   endfunction

endpackage

// File: rtl/decoder_3x8_stream_code_fifo.sv
// Generic W-wide, DEPTH-deep synchronous FIFO with flush, occupancy and full/empty flags.
module code_fifo #(
   parameter int W     = 3,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_clear,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [W-1:0]               i_data,
   output logic [W-1:0]               o_data,
   output logic [$clog2(DEPTH):0]     o_level,
   output logic                       o_full,
   output logic                       o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [LW-1:0] r_level;
   logic          w_push;
   logic          w_pop;

   // Full blocks a push even when a pop fires on the same edge; empty ignores pops.
   assign o_full  = (r_level == LW'(DEPTH));
   assign o_empty = (r_level == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; level and pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (w_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_level = r_level;

endmodule

// File: rtl/decoder_3x8_stream.sv
// Streaming 3-to-8 one-hot decoder: buffers codes in a FIFO and presents them as one-hot words, gated by En.
module decoder_3x8_stream
   import decoder_3x8_stream_pkg::*;
#(
   parameter int IW    = IW_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     En,
   input  logic                     clear,
   input  logic [IW-1:0]            in_code,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [(2**IW)-1:0]       out_onehot,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level
);

   logic [IW-1:0] w_head;
   logic          w_full;
   logic          w_empty;
   logic          w_pop;

   code_fifo #(
      .W     (IW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_clear (clear),
      .i_push  (in_valid),
      .i_pop   (w_pop),
      .i_data  (in_code),
      .o_data  (w_head),
      .o_level (level),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // With En low nothing is offered, so nothing can be consumed.
   assign in_ready   = !w_full;
   assign out_valid  = En && !w_empty;
   assign w_pop      = out_valid && out_ready;
   assign out_onehot = out_valid ? onehot_decode(w_head) : '0;

endmodule

// File: tb/tb_decoder_3x8_stream.sv
// Directed self-checking bench for decoder_3x8_stream with hand-computed expectations.
module tb_decoder_3x8_stream;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       En = 1'b1;
   logic       clear = 1'b0;
   logic [2:0] in_code = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] out_onehot;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [2:0] level;

   int n_checks = 0;
   int n_errors = 0;

   decoder_3x8_stream dut (
      .clk        (clk),
      .rst        (rst),
      .En         (En),
      .clear      (clear),
      .in_code    (in_code),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_onehot (out_onehot),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .level      (level)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [2:0] c);
      in_code  = c;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      // Reset state while rst is asserted
      #2;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_onehot", 32'(out_onehot), 32'h00);
      check("rst_ready", 32'(in_ready), 32'd1);
      check("rst_level", 32'(level), 32'd0);
      #10 rst = 1'b0;
      tick();

      // Codes 0..7 streamed with out_ready high: one cycle latency, level stays at 1
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int c = 0; c < 8; c++) begin
         in_code = 3'(c);
         tick();
         check($sformatf("stream_onehot_%0d", c), 32'(out_onehot), 32'(8'h01 << c));
         check($sformatf("stream_level_%0d", c), 32'(level), 32'd1);
      end
      in_valid = 1'b0;
      tick();
      check("stream_drain_level", 32'(level), 32'd0);
      check("stream_drain_valid", 32'(out_valid), 32'd0);

      // Fill to full with the consumer stalled; the fifth code must be refused
      out_ready = 1'b0;
      push(3'd3);
      push(3'd6);
      push(3'd1);
      push(3'd7);
      check("full_ready", 32'(in_ready), 32'd0);
      check("full_level", 32'(level), 32'd4);
      in_code  = 3'd0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("full_reject_level", 32'(level), 32'd4);
      check("full_head", 32'(out_onehot), 32'h08);
      out_ready = 1'b1;
      #1 check("drain_0", 32'(out_onehot), 32'h08);
      tick();
      check("drain_1", 32'(out_onehot), 32'h40);
      tick();
      check("drain_2", 32'(out_onehot), 32'h02);
      tick();
      check("drain_3", 32'(out_onehot), 32'h80);
      tick();
      check("drain_empty_level", 32'(level), 32'd0);
      check("drain_empty_onehot", 32'(out_onehot), 32'h00);

      // En low holds the FIFO; raising En shows the head in the same cycle
      En = 1'b0;
      push(3'd2);
      push(3'd4);
      check("en0_valid", 32'(out_valid), 32'd0);
      check("en0_onehot", 32'(out_onehot), 32'h00);
      check("en0_level", 32'(level), 32'd2);
      En = 1'b1;
      #1;
      check("en1_valid", 32'(out_valid), 32'd1);
      check("en1_onehot", 32'(out_onehot), 32'h04);
      tick();
      check("en1_next", 32'(out_onehot), 32'h10);
      tick();
      check("en1_empty", 32'(level), 32'd0);

      // En toggling with out_ready high: only En=1 cycles pop
      out_ready = 1'b0;
      push(3'd5);
      push(3'd6);
      out_ready = 1'b1;
      En = 1'b0;
      tick();
      check("entog_hold_level", 32'(level), 32'd2);
      En = 1'b1;
      tick();
      check("entog_pop_level", 32'(level), 32'd1);
      check("entog_pop_head", 32'(out_onehot), 32'h40);
      tick();
      check("entog_empty", 32'(level), 32'd0);

      // Simultaneous push and pop at level 2, pointers wrap
      out_ready = 1'b0;
      push(3'd1);
      push(3'd2);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_code = 3'((i + 3) % 8);
         #1 check($sformatf("pp_head_%0d", i), 32'(out_onehot), 32'(8'h01 << (i + 1)));
         tick();
         check($sformatf("pp_level_%0d", i), 32'(level), 32'd2);
      end
      in_valid = 1'b0;
      #1 check("pp_tail_0", 32'(out_onehot), 32'h80);
      tick();
      check("pp_tail_1", 32'(out_onehot), 32'h01);
      tick();
      check("pp_empty", 32'(level), 32'd0);

      // Clear with a same-cycle push discards everything
      out_ready = 1'b0;
      push(3'd1);
      push(3'd2);
      push(3'd3);
      check("clr_pre_level", 32'(level), 32'd3);
      clear    = 1'b1;
      in_code  = 3'd5;
      in_valid = 1'b1;
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      check("clr_level", 32'(level), 32'd0);
      check("clr_valid", 32'(out_valid), 32'd0);
      check("clr_ready", 32'(in_ready), 32'd1);
      tick();
      check("clr_stays_empty", 32'(level), 32'd0);

      // Asynchronous reset between edges with three entries held
      push(3'd4);
      push(3'd5);
      push(3'd6);
      out_ready = 1'b1;
      #1 check("arst_pre_onehot", 32'(out_onehot), 32'h10);
      #2 rst = 1'b1;
      #1;
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_onehot", 32'(out_onehot), 32'h00);
      check("arst_level", 32'(level), 32'd0);
      check("arst_ready", 32'(in_ready), 32'd1);
      #2 rst = 1'b0;
      tick();
      check("arst_after_level", 32'(level), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
